// File: rtl/uff_pkg.sv
// Shared mode encodings and widths for the universal flip-flop register.
package uff_pkg;

   localparam int unsigned UFF_MODE_W = 3;

   typedef enum logic [UFF_MODE_W-1:0] {
      UFF_HOLD  = 3'b000,
      UFF_LOAD  = 3'b001,
      UFF_JK    = 3'b010,
      UFF_TOG   = 3'b011,
      UFF_SHL   = 3'b100,
      UFF_SHR   = 3'b101,
      UFF_CNTUP = 3'b110,
      UFF_CNTDN = 3'b111
   } uff_mode_e;

endpackage

// File: rtl/uff_bit.sv
// Per-bit next-state for HOLD/LOAD/JK/TOG; every other mode returns the current bit.
module uff_bit
   import uff_pkg::*;
(
   input  uff_mode_e mode_i,
   input  logic      q_i,
   input  logic      d_i,
   input  logic      j_i,
   input  logic      k_i,
   input  logic      t_i,
   output logic      q_d_o
);

   always_comb begin
      q_d_o = q_i;
      unique case (mode_i)
         UFF_LOAD: q_d_o = d_i;
         UFF_JK: begin
            unique case ({j_i, k_i})
               2'b01:   q_d_o = 1'b0;
               2'b10:   q_d_o = 1'b1;
               2'b11:   q_d_o = ~q_i;
               default: q_d_o = q_i;
            endcase
         end
         UFF_TOG: q_d_o = q_i ^ t_i;
         default: q_d_o = q_i;
      endcase
   end

endmodule

// File: rtl/universal_ff_reg.sv
// Universal register: load, JK, toggle, shift and count modes with wrap flag.
// Shift modes are built only when UNIVERSAL_FF_REG_SHIFT_EN is defined.
module universal_ff_reg
   import uff_pkg::*;
#(
   parameter int unsigned           WIDTH     = 8,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
   input  logic                  C,
   input  logic                  R,
   input  logic                  EN,
   input  logic [UFF_MODE_W-1:0] MODE,
   input  logic [WIDTH-1:0]      D,
   input  logic [WIDTH-1:0]      J,
   input  logic [WIDTH-1:0]      K,
   input  logic [WIDTH-1:0]      T,
   input  logic                  SI,
   output logic [WIDTH-1:0]      Q,
   output logic [WIDTH-1:0]      nQ,
   output logic                  SO,
   output logic                  CO
);

   uff_mode_e        mode;
   logic [WIDTH-1:0] q_q, q_d, bit_d;
   logic             co_q, co_d;

   assign mode = uff_mode_e'(MODE);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      uff_bit u_bit (
         .mode_i (mode),
         .q_i    (q_q[i]),
         .d_i    (D[i]),
         .j_i    (J[i]),
         .k_i    (K[i]),
         .t_i    (T[i]),
         .q_d_o  (bit_d[i])
      );
   end

   always_comb begin
      q_d  = bit_d;
      co_d = 1'b0;
      unique case (mode)
         UFF_CNTUP: begin
            q_d  = q_q + WIDTH'(1);
            co_d = &q_q;
         end
         UFF_CNTDN: begin
            q_d  = q_q - WIDTH'(1);
            co_d = ~|q_q;
         end
`ifdef UNIVERSAL_FF_REG_SHIFT_EN
         UFF_SHL: q_d = {q_q[WIDTH-2:0], SI};
         UFF_SHR: q_d = {SI, q_q[WIDTH-1:1]};
`endif
         default: ;
      endcase
      if (!EN) begin
         q_d  = q_q;
         co_d = co_q;
      end
   end

`ifdef UNIVERSAL_FF_REG_SHIFT_EN
   always_comb begin
      SO = 1'b0;
      unique case (mode)
         UFF_SHL: SO = q_q[WIDTH-1];
         UFF_SHR: SO = q_q[0];
         default: SO = 1'b0;
      endcase
   end
`else
   logic unused_si;
   assign unused_si = SI;
   assign SO        = 1'b0;
`endif

   always_ff @(posedge C or posedge R) begin
      if (R) begin
         q_q  <= RESET_VAL;
         co_q <= 1'b0;
      end else begin
         q_q  <= q_d;
         co_q <= co_d;
      end
   end

   assign Q  = q_q;
   assign nQ = ~q_q;
   assign CO = co_q;

endmodule

// File: tb/tb_universal_ff_reg.sv
// Self-checking bench for universal_ff_reg (WIDTH=8, RESET_VAL=0): directed table,
// reset sequences and randomized traffic against an arithmetic reference model.
module tb_universal_ff_reg;

   typedef struct {
      logic [2:0] mode;
      logic       en;
      logic [7:0] d, j, k, t;
      logic       si;
      logic       exp_so;
      logic [7:0] exp_q;
      logic       exp_co;
   } vec_t;

   logic       C = 1'b0, R = 1'b1, EN = 1'b0, SI = 1'b0;
   logic [2:0] MODE = 3'b000;
   logic [7:0] D = '0, J = '0, K = '0, T = '0;
   logic [7:0] Q, nQ;
   logic       SO, CO;

   int n_checks = 0;
   int n_err    = 0;
   logic [7:0] m_q  = 8'h00;
   logic       m_co = 1'b0;
   bit         shift_en;

   universal_ff_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
      .C(C), .R(R), .EN(EN), .MODE(MODE), .D(D), .J(J), .K(K), .T(T), .SI(SI),
      .Q(Q), .nQ(nQ), .SO(SO), .CO(CO)
   );

   always #5 C = ~C;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: rules applied with plain arithmetic, returns {wrap, next}.
   function automatic logic [8:0] ref_next(input logic [2:0] mode, input logic [7:0] q,
                                           input logic [7:0] d, input logic [7:0] j,
                                           input logic [7:0] k, input logic [7:0] t,
                                           input logic si);
      logic [7:0] n;
      logic       w;
      n = q;
      w = 1'b0;
      case (mode)
         3'd1: n = d;
         3'd2: for (int i = 0; i < 8; i++) begin
            if (j[i] && k[i]) n[i] = ~q[i];
            else if (j[i])    n[i] = 1'b1;
            else if (k[i])    n[i] = 1'b0;
         end
         3'd3: for (int i = 0; i < 8; i++) if (t[i]) n[i] = ~q[i];
         3'd4: if (shift_en) n = 8'((int'(q) * 2 + int'(si)) % 256);
         3'd5: if (shift_en) n = 8'(int'(q) / 2 + (si ? 128 : 0));
         3'd6: begin n = 8'((int'(q) + 1) % 256); w = (q == 8'd255); end
         3'd7: begin n = 8'((int'(q) + 255) % 256); w = (q == 8'd0); end
         default: n = q;
      endcase
      return {w, n};
   endfunction

   function automatic logic ref_so(input logic [2:0] mode, input logic [7:0] q);
      if (!shift_en) return 1'b0;
      if (mode == 3'd4) return q[7];
      if (mode == 3'd5) return q[0];
      return 1'b0;
   endfunction

   // Apply one vector, check SO before the edge and Q/nQ/CO after it.
   task automatic step(input string name, input vec_t v);
      logic [8:0] r;
      MODE = v.mode; EN = v.en; D = v.d; J = v.j; K = v.k; T = v.t; SI = v.si;
      #1;
      chk({name, ".so"}, {7'd0, SO}, {7'd0, v.exp_so});
      @(posedge C);
      #1;
      chk({name, ".q"}, Q, v.exp_q);
      chk({name, ".nq"}, nQ, ~v.exp_q);
      chk({name, ".co"}, {7'd0, CO}, {7'd0, v.exp_co});
      r = ref_next(v.mode, m_q, v.d, v.j, v.k, v.t, v.si);
      if (v.en) begin
         m_q  = r[7:0];
         m_co = r[8];
      end
   endtask

   function automatic vec_t mk(input logic [2:0] mode, input logic en, input logic [7:0] d,
                               input logic [7:0] j, input logic [7:0] k, input logic [7:0] t,
                               input logic si, input logic so, input logic [7:0] q,
                               input logic co);
      vec_t v;
      v.mode = mode; v.en = en; v.d = d; v.j = j; v.k = k; v.t = t; v.si = si;
      v.exp_so = so; v.exp_q = q; v.exp_co = co;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      vec_t v;
      logic [8:0] r;
`ifdef UNIVERSAL_FF_REG_SHIFT_EN
      shift_en = 1'b1;
`else
      shift_en = 1'b0;
`endif
      // Directed table; expectations are hand-derived.
      vecs.push_back(mk(3'd1, 1, 8'hF0, 0, 0, 0, 0, 0, 8'hF0, 0));
      vecs.push_back(mk(3'd2, 1, 0, 8'h3C, 8'hCC, 0, 0, 0, 8'h3C, 0));
      vecs.push_back(mk(3'd1, 1, 8'h0F, 0, 0, 0, 0, 0, 8'h0F, 0));
      vecs.push_back(mk(3'd3, 1, 0, 0, 0, 8'hFF, 0, 0, 8'hF0, 0));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(3'd3, 0, 0, 0, 0, 8'hFF, 0, 0, 8'hF0, 0));
      vecs.push_back(mk(3'd1, 1, 8'hFE, 0, 0, 0, 0, 0, 8'hFE, 0));
      vecs.push_back(mk(3'd6, 1, 0, 0, 0, 0, 0, 0, 8'hFF, 0));
      vecs.push_back(mk(3'd6, 1, 0, 0, 0, 0, 0, 0, 8'h00, 1));
      vecs.push_back(mk(3'd6, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1));
      vecs.push_back(mk(3'd6, 1, 0, 0, 0, 0, 0, 0, 8'h01, 0));
      vecs.push_back(mk(3'd1, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0));
      vecs.push_back(mk(3'd7, 1, 0, 0, 0, 0, 0, 0, 8'hFF, 1));
      vecs.push_back(mk(3'd0, 1, 8'h55, 8'hFF, 0, 8'hFF, 1, 0, 8'hFF, 0));
      vecs.push_back(mk(3'd1, 1, 8'h81, 0, 0, 0, 0, 0, 8'h81, 0));
`ifdef UNIVERSAL_FF_REG_SHIFT_EN
      vecs.push_back(mk(3'd4, 1, 0, 0, 0, 0, 0, 1, 8'h02, 0));
      vecs.push_back(mk(3'd1, 1, 8'h81, 0, 0, 0, 0, 0, 8'h81, 0));
      vecs.push_back(mk(3'd5, 1, 0, 0, 0, 0, 1, 1, 8'hC0, 0));
`else
      vecs.push_back(mk(3'd4, 1, 0, 0, 0, 0, 1, 0, 8'h81, 0));
      vecs.push_back(mk(3'd5, 1, 0, 0, 0, 0, 1, 0, 8'h81, 0));
`endif

      // Reset holds everything regardless of clock and inputs.
      #3;
      chk("rst.q", Q, 8'h00);
      chk("rst.nq", nQ, 8'hFF);
      chk("rst.co", {7'd0, CO}, 8'h00);
      EN = 1'b1; MODE = 3'd1; D = 8'hA5;
      repeat (2) @(posedge C);
      #1;
      chk("rst_ign.q", Q, 8'h00);
      @(negedge C);
      R = 1'b0;

      foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

      // Async reset mid-count, away from any edge.
      step("pre59", mk(3'd1, 1, 8'h59, 0, 0, 0, 0, 0, 8'h59, 0));
      step("cnt5a", mk(3'd6, 1, 0, 0, 0, 0, 0, 0, 8'h5A, 0));
      #2;
      R = 1'b1;
      #1;
      chk("arst.q", Q, 8'h00);
      chk("arst.nq", nQ, 8'hFF);
      chk("arst.co", {7'd0, CO}, 8'h00);
      @(negedge C);
      R = 1'b0;
      m_q = 8'h00; m_co = 1'b0;
      step("post_rst", mk(3'd6, 1, 0, 0, 0, 0, 0, 0, 8'h01, 0));

      // Reset clears a pending CO.
      step("ldff", mk(3'd1, 1, 8'hFF, 0, 0, 0, 0, 0, 8'hFF, 0));
      step("wrap", mk(3'd6, 1, 0, 0, 0, 0, 0, 0, 8'h00, 1));
      #2;
      R = 1'b1;
      #1;
      chk("arst_co.co", {7'd0, CO}, 8'h00);
      @(negedge C);
      R = 1'b0;
      m_q = 8'h00; m_co = 1'b0;

      // Randomized traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         v.mode = 3'($urandom_range(0, 7));
         v.en   = ($urandom_range(0, 3) != 0);
         v.d    = 8'($urandom);
         v.j    = 8'($urandom);
         v.k    = 8'($urandom);
         v.t    = 8'($urandom);
         v.si   = 1'($urandom);
         if ($urandom_range(0, 15) == 0) v.d = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
         v.exp_so = ref_so(v.mode, m_q);
         r = ref_next(v.mode, m_q, v.d, v.j, v.k, v.t, v.si);
         v.exp_q  = v.en ? r[7:0] : m_q;
         v.exp_co = v.en ? r[8] : m_co;
         step($sformatf("rnd%0d", n), v);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/universal_ff_reg.md
UNIVERSAL_FF_REG -- requirements
Module: universal_ff_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..32).
REQ-002 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into Q on reset.
REQ-003 SHALL have port C  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port R  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port EN  input  1  clock enable; 0 holds all state.
REQ-006 SHALL have port MODE  input  3  operation select (see REQ-012).
REQ-007 SHALL have ports D, J, K, T  input  WIDTH each  per-bit data/JK/toggle operands.
REQ-008 SHALL have port SI  input  1  serial input for shift modes.
REQ-009 SHALL have ports Q, nQ  output  WIDTH  register state and its bitwise complement.
REQ-010 SHALL have port SO  output  1  serial output.
REQ-011 SHALL have port CO  output  1  registered wrap flag for count modes.

Function
REQ-012 SHALL decode MODE: 000 HOLD, 001 LOAD (Q<=D), 010 JK, 011 TOG, 100 SHL, 101 SHR, 110 CNTUP, 111 CNTDN.
REQ-013 SHALL, in JK mode, per bit: J=0,K=0 hold; J=0,K=1 clear; J=1,K=0 set; J=1,K=1 toggle.
REQ-014 SHALL, in TOG mode, invert Q[i] when T[i]=1 and hold it otherwise.
REQ-015 SHALL, in SHL, shift Q[WIDTH-1:1]<=Q[WIDTH-2:0] with Q[0]<=SI; in SHR, Q[WIDTH-2:0]<=Q[WIDTH-1:1] with Q[WIDTH-1]<=SI.
REQ-016 SHALL, in CNTUP/CNTDN, add/subtract 1 modulo 2^WIDTH (all-ones+1 -> 0; 0-1 -> all-ones).
REQ-017 SHALL update Q one rising edge after inputs are sampled (latency 1); with EN=0 Q and CO hold.
REQ-018 SHALL drive nQ = ~Q combinationally at all times, including during reset.
REQ-019 SHALL drive SO combinationally: Q[WIDTH-1] in SHL, Q[0] in SHR, 0 in all other modes.
REQ-020 SHALL set CO=1 for exactly one cycle after an enabled edge that wraps the count (CNTUP from all-ones, CNTDN from zero); any other enabled edge clears CO; CO holds when EN=0.
REQ-021 SHALL treat a MODE change between edges as immediate; the MODE value present at the edge governs that edge only.

Reset
REQ-022 SHALL, while R=1, force Q=RESET_VAL, nQ=~RESET_VAL, CO=0, independent of C and EN.
REQ-023 SHALL let R override any in-progress operation; the first edge after R falls operates on RESET_VAL.
REQ-024 SHALL ignore all inputs other than R while R=1.

Configuration
REQ-025 SHALL compile shift modes only when macro UNIVERSAL_FF_REG_SHIFT_EN is defined.
REQ-026 SHALL, without UNIVERSAL_FF_REG_SHIFT_EN, treat MODE 100/101 as HOLD, tie SO to 0, and leave SI unused.

Structure
REQ-027 SHALL place MODE encodings (UFF_HOLD..UFF_CNTDN) and the 3-bit mode width constant in shared package uff_pkg.
REQ-028 SHALL implement per-bit HOLD/LOAD/JK/TOG next-state logic in sub-module uff_bit, instantiated WIDTH times; shift and count are handled at the word level in universal_ff_reg.

Verification (WIDTH=8, RESET_VAL=0)
REQ-029 SHALL check reset: R=1 mid-count at Q=0x5A -> Q=0x00, nQ=0xFF, CO=0 immediately without a clock edge.
REQ-030 SHALL check JK: Q=0xF0, J=0x3C, K=0xCC, MODE=010 -> Q=0x3C after one edge.
REQ-031 SHALL check TOG then EN gating: Q=0x0F, T=0xFF, MODE=011 -> 0xF0; EN=0 for 3 edges -> stays 0xF0.
REQ-032 SHALL check count wrap: Q=0xFE, CNTUP two edges -> 0xFF then 0x00 with CO=1; next edge Q=0x01, CO=0; CNTDN from 0x00 -> 0xFF, CO=1.
REQ-033 SHALL check shift (macro defined): Q=0x81, SI=0, SHL -> Q=0x02, SO=1 before the edge; SHR from 0x81 with SI=1 -> 0xC0.
REQ-034 SHALL check the macro undefined: MODE=100 with Q=0x81 -> Q stays 0x81, SO=0.
